// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: operand width,
// feeder sequencer states and the feed-length helper.
package systolic_pkg;

   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_FLUSH
   } feeder_state_e;

   // Cycles needed for the last skewed operand pair to reach PE(N-1,N-1).
   function automatic int unsigned feed_steps(input int unsigned n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand capture and array-edge bus between a requester and systolic_feeder.
interface systolic_feeder_if
   import systolic_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic                    i_start;
   logic [N*N*DATA_W-1:0]   i_matA;
   logic [N*N*DATA_W-1:0]   i_matB;
   logic                    o_busy;
   logic                    o_doProcess;
   logic [N*DATA_W-1:0]     o_rowA;
   logic [N*DATA_W-1:0]     o_colB;
   logic                    o_done;

   modport master (
      output i_start, i_matA, i_matB,
      input  o_busy, o_doProcess, o_rowA, o_colB, o_done
   );

   modport slave (
      input  i_start, i_matA, i_matB,
      output o_busy, o_doProcess, o_rowA, o_colB, o_done
   );

endinterface

// File: rtl/systolic_feeder_skew_mux.sv
// One edge lane of the feeder: picks element (t - LANE) of an N-element
// vector, or zero when that index falls outside the vector.
module skew_mux
   import systolic_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned LANE   = 0,
   parameter int unsigned CNT_W  = 4
) (
   input  logic [N*DATA_W-1:0] vec_i,
   input  logic [CNT_W-1:0]    t_i,
   output logic [DATA_W-1:0]   sel_o
);

   always_comb begin
      sel_o = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (32'(t_i) == LANE + k) sel_o = vec_i[k*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Latches two NxN operand matrices on start and streams them, diagonally
// skewed and zero padded, into the west and north edges of the systolic array.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input logic               i_clk,
   input logic               i_arst,
   systolic_feeder_if.slave  fd
);

   localparam int unsigned STEPS = feed_steps(N);
   localparam int unsigned CNT_W = $clog2(3 * N - 1);
   localparam int unsigned VEC_W = N * DATA_W;
   localparam int unsigned MAT_W = N * N * DATA_W;
   localparam logic [CNT_W-1:0] LAST_T = CNT_W'(STEPS - 1);

   feeder_state_e    state_q, state_d;
   logic [CNT_W-1:0] t_q, t_d;
   logic [MAT_W-1:0] matA_q, matA_d;
   logic [MAT_W-1:0] matB_q, matB_d;
   logic             busy_q, busy_d;
   logic             doproc_q, doproc_d;
   logic             done_q, done_d;
   logic [VEC_W-1:0] rowA_q, rowA_d;
   logic [VEC_W-1:0] colB_q, colB_d;
   logic [VEC_W-1:0] rowA_sel, colB_sel;
   logic [VEC_W-1:0] colvec [N];

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      matA_d  = matA_q;
      matB_d  = matB_q;
      case (state_q)
         ST_IDLE: begin
            if (fd.i_start) begin
               state_d = ST_FEED;
               t_d     = '0;
               matA_d  = fd.i_matA;
               matB_d  = fd.i_matB;
            end
         end
         ST_FEED: begin
            t_d = t_q + CNT_W'(1);
            if (t_q == LAST_T) state_d = ST_FLUSH;
         end
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed from next-state values so the first skewed pair
   // appears in the cycle right after the start is accepted.
   always_comb begin
      busy_d   = (state_d != ST_IDLE);
      doproc_d = (state_d == ST_FEED);
      done_d   = (state_d == ST_FLUSH);
      rowA_d   = doproc_d ? rowA_sel : '0;
      colB_d   = doproc_d ? colB_sel : '0;
   end

   // Column j of B gathered into a contiguous vector indexed by row k.
   always_comb begin
      colvec = '{default: '0};
      for (int unsigned j = 0; j < N; j++) begin
         for (int unsigned k = 0; k < N; k++) begin
            colvec[j][k*DATA_W +: DATA_W] = matB_d[(k*N+j)*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      skew_mux #(
         .N      (N),
         .DATA_W (DATA_W),
         .LANE   (g),
         .CNT_W  (CNT_W)
      ) u_row (
         .vec_i (matA_d[g*VEC_W +: VEC_W]),
         .t_i   (t_d),
         .sel_o (rowA_sel[g*DATA_W +: DATA_W])
      );

      skew_mux #(
         .N      (N),
         .DATA_W (DATA_W),
         .LANE   (g),
         .CNT_W  (CNT_W)
      ) u_col (
         .vec_i (colvec[g]),
         .t_i   (t_d),
         .sel_o (colB_sel[g*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q  <= ST_IDLE;
         t_q      <= '0;
         matA_q   <= '0;
         matB_q   <= '0;
         busy_q   <= 1'b0;
         doproc_q <= 1'b0;
         done_q   <= 1'b0;
         rowA_q   <= '0;
         colB_q   <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         matA_q   <= matA_d;
         matB_q   <= matB_d;
         busy_q   <= busy_d;
         doproc_q <= doproc_d;
         done_q   <= done_d;
         rowA_q   <= rowA_d;
         colB_q   <= colB_d;
      end
   end

   assign fd.o_busy      = busy_q;
   assign fd.o_doProcess = doproc_q;
   assign fd.o_done      = done_q;
   assign fd.o_rowA      = rowA_q;
   assign fd.o_colB      = colB_q;

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream sequencer for the N×N systolic multiply array. It captures two N×N 8-bit operand matrices on a start request and streams them into the array's west (row) and north (column) edges with the diagonal skew the array requires. It drives the shared process-enable for every processing element (PE) and flags the single cycle in which all PE accumulators hold the finished product.

## Interface
Parameters:
- N, 4, array dimension (rows = columns = N), N ≥ 2
- DATA_W, 8, operand width; must match the PE operand width

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_arst  in  1  reset, asynchronous, active-high
- i_start  in  1  start request; sampled only in IDLE
- i_matA  in  N*N*DATA_W  matrix A, row-major; element A[i][k] at bits [(i*N+k)*DATA_W +: DATA_W]
- i_matB  in  N*N*DATA_W  matrix B, row-major; element B[k][j] at bits [(k*N+j)*DATA_W +: DATA_W]
- o_busy  out  1  high from the cycle after start is accepted through the o_done cycle
- o_doProcess  out  1  process enable, broadcast to all PEs
- o_rowA  out  N*DATA_W  west-edge operand; slice i drives the a input of PE(i,0)
- o_colB  out  N*DATA_W  north-edge operand; slice j drives the b input of PE(0,j)
- o_done  out  1  one-cycle pulse: PE accumulators hold C = A×B

## Operation
- States:
  - IDLE: wait for a request.
  - FEED: stream skewed operands.
  - FLUSH: single cycle; results are valid.
- IDLE → FEED when i_start=1.
  - On that edge, latch i_matA/i_matB into internal registers and clear the step counter t to 0.
  - Inputs are not sampled again until the next start.
- FEED, step t = 0 … 3N−3 (3N−2 cycles):
  - o_doProcess = 1.
  - o_rowA slice i = A[i][t−i] when 0 ≤ t−i < N, else 0.
  - o_colB slice j = B[t−j][j] when 0 ≤ t−j < N, else 0.
  - Zero padding is mandatory. PEs hold their forwarding registers when disabled, so stale data must never be driven.
- FEED → FLUSH after step t = 3N−3.
- FLUSH: o_doProcess=0, o_done=1, o_rowA=o_colB=0. Then → IDLE.
- In FLUSH the PEs still hold their final accumulator. Their accumulators clear on the following edge because doProcess is low. Downstream capture must happen in the o_done cycle.
- i_start is ignored in FEED and FLUSH. A start held high through FLUSH is accepted in the next IDLE cycle.
- Step counter is $clog2(3N−1) bits wide and saturates-free: it is reset to 0 on entry to FEED only.
- Skew selection is pure indexing of the latched matrices by t. There is no arithmetic on data.

## Timing
- Reset values:
  - State = IDLE; t = 0; latched matrices = 0.
  - o_busy = o_doProcess = o_done = 0.
  - o_rowA = o_colB = 0.
- All outputs are registered (no combinational path from any input to any output).
- i_start=1 sampled at edge e0 (IDLE). Then:
  - o_busy and o_doProcess rise after e0.
  - The first skewed data (A[0][0], B[0][0]; other slices 0) is presented in that same cycle.
  - o_doProcess stays high for exactly 3N−2 cycles.
  - o_done is high in cycle 3N−1 after e0 (the cycle immediately after the last doProcess cycle).
  - o_busy falls with o_done.
- Minimum start-to-start spacing is 3N cycles (back-to-back start).
- Reset asserted mid-FEED: all outputs go to 0 asynchronously and state → IDLE. No o_done is issued. The array is left with partial sums, which clear on its own reset or the next disabled cycle.

## Structure
- Shared package systolic_pkg:
  - DATA_W default
  - feeder state enum (IDLE, FEED, FLUSH)
  - localparam helper for step count (3N−2)
- The PE uses the same DATA_W.
- One natural sub-module: skew_mux. It is instanced 2N times, each parameterised by lane index. It selects element index t−lane from a length-N vector, or 0 when out of range. It is combinational feeding the output registers.
- Sequencer FSM and counter stay in systolic_feeder.

## Test plan
- Reset: i_arst pulse → all outputs 0; i_start held low for 20 cycles → o_doProcess never rises.
- N=4, A=identity, B[k][j]=4k+j+1 (1…16), start:
  - o_doProcess high exactly 10 cycles, then o_done one cycle later.
  - With a PE array attached, C equals B (1…16) in the o_done cycle.
- Skew check, N=4, A[i][k]=16i+k+1:
  - Step 0: o_rowA = {0,0,0,1}.
  - Step 3: slice 3 = 49 (A[3][0]), slice 0 = 4 (A[0][3]).
  - Step 9: all slices 0.
- Start while busy: second i_start pulses during FEED and FLUSH → ignored; exactly one o_done; o_busy falls normally.
- Back-to-back: i_start held high continuously → FEED re-entered in the cycle after o_done; second operands latched at that acceptance edge; o_done period = 12 cycles.
- Mid-run reset at step 5 → outputs 0 immediately; no o_done; subsequent start runs a full, correct 10-cycle sequence.
